// File: rtl/stdcore_upsizer_if.sv
// Handshake bundle for the upsizer: narrow item stream in, packed word stream out.
interface stdcore_upsizer_if #(
    parameter int DW    = 8,
    parameter int RATIO = 4
);
    logic [DW-1:0]       p;
    logic                p_last;
    logic                p_val;
    logic                p_rdy;
    logic [DW*RATIO-1:0] c;
    logic [RATIO-1:0]    c_keep;
    logic                c_last;
    logic                c_val;
    logic                c_rdy;

    modport master (
        output p, p_last, p_val, c_rdy,
        input  p_rdy, c, c_keep, c_last, c_val
    );

    modport slave (
        input  p, p_last, p_val, c_rdy,
        output p_rdy, c, c_keep, c_last, c_val
    );
endinterface

// File: rtl/stdcore_upsizer.sv
// Packs RATIO narrow items into one wide word with keep/last framing.
// The completing item bypasses the accumulator straight into the output register.
module stdcore_upsizer #(
    parameter int DW    = 8,
    parameter int RATIO = 4,
    parameter int CW    = 2
) (
    input logic              clk,
    input logic              rst_n,
    stdcore_upsizer_if.slave bus
);
    localparam int            AL        = RATIO - 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    logic [AL*DW-1:0]    acc_q, acc_d;
    logic [AL-1:0]       keep_q, keep_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW*RATIO-1:0] c_q, c_d;
    logic [RATIO-1:0]    ckeep_q, ckeep_d;
    logic                clast_q, clast_d;
    logic                cval_q, cval_d;
    logic                at_end;
    logic                p_rdy;
    logic                accept;
    logic                complete;

    assign at_end   = (cnt_q == LAST_LANE);
    assign p_rdy    = !cval_q || bus.c_rdy || (!at_end && !bus.p_last);
    assign accept   = bus.p_val && p_rdy;
    assign complete = at_end || bus.p_last;

    assign bus.p_rdy  = p_rdy;
    assign bus.c      = c_q;
    assign bus.c_keep = ckeep_q;
    assign bus.c_last = clast_q;
    assign bus.c_val  = cval_q;

    always_comb begin
        acc_d   = acc_q;
        keep_d  = keep_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        ckeep_d = ckeep_q;
        clast_d = clast_q;
        cval_d  = cval_q;
        if (cval_q && bus.c_rdy) begin
            cval_d = 1'b0;
        end
        if (accept) begin
            if (complete) begin
                // Lanes above cnt are already zero in the accumulator.
                c_d     = {{DW{1'b0}}, acc_q};
                ckeep_d = {1'b0, keep_q};
                for (int k = 0; k < RATIO; k++) begin
                    if (CW'(k) == cnt_q) begin
                        c_d[k*DW +: DW] = bus.p;
                        ckeep_d[k]      = 1'b1;
                    end
                end
                clast_d = bus.p_last;
                cval_d  = 1'b1;
                acc_d   = '0;
                keep_d  = '0;
                cnt_d   = '0;
            end else begin
                for (int k = 0; k < AL; k++) begin
                    if (CW'(k) == cnt_q) begin
                        acc_d[k*DW +: DW] = bus.p;
                        keep_d[k]         = 1'b1;
                    end
                end
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            keep_q  <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            ckeep_q <= '0;
            clast_q <= 1'b0;
            cval_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            keep_q  <= keep_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            ckeep_q <= ckeep_d;
            clast_q <= clast_d;
            cval_q  <= cval_d;
        end
    end
endmodule

// File: tb/tb_stdcore_upsizer.sv
// Directed and random stimulus for stdcore_upsizer with a queue scoreboard.
module tb_stdcore_upsizer;
    typedef struct packed {
        logic [31:0] c;
        logic [3:0]  k;
        logic        l;
    } word_t;

    logic  clk;
    logic  rst_n;
    int    checks;
    int    errors;
    int    nwords;
    int    cyc;
    int    stalls;
    bit    rnd;
    word_t exp_q[$];
    logic [31:0] macc;
    logic [3:0]  mkeep;
    int          mcnt;

    stdcore_upsizer_if #(.DW(8), .RATIO(4)) bus ();

    stdcore_upsizer #(.DW(8), .RATIO(4), .CW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: the word at the queue head is what the output register must show.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            macc  = '0;
            mkeep = '0;
            mcnt  = 0;
        end else begin
            check("c_val", 32'(bus.c_val), 32'(exp_q.size() != 0));
            check("p_rdy", 32'(bus.p_rdy),
                  32'(exp_q.size() == 0 || bus.c_rdy ||
                      (mcnt < 3 && !bus.p_last)));
            if (exp_q.size() != 0 && bus.c_val) begin
                check("sb_c", bus.c, exp_q[0].c);
                check("sb_keep", 32'(bus.c_keep), 32'(exp_q[0].k));
                check("sb_last", 32'(bus.c_last), 32'(exp_q[0].l));
                if (bus.c_rdy) begin
                    void'(exp_q.pop_front());
                    nwords++;
                end
            end
            if (bus.p_val && bus.p_rdy) begin
                macc[mcnt*8 +: 8] = bus.p;
                mkeep[mcnt]       = 1'b1;
                if (mcnt == 3 || bus.p_last) begin
                    exp_q.push_back('{c: macc, k: mkeep, l: bus.p_last});
                    macc  = '0;
                    mkeep = '0;
                    mcnt  = 0;
                end else begin
                    mcnt++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd) bus.c_rdy = ($urandom_range(3) == 0);
        end
    endtask

    task automatic put(input logic [7:0] d, input logic l);
        int  n;
        bit  acc;
        n = 0;
        if (rnd) begin
            while ($urandom_range(3) != 0) idle(1);
        end
        bus.p      = d;
        bus.p_last = l;
        bus.p_val  = 1'b1;
        forever begin
            @(negedge clk);
            acc = bus.p_rdy;
            @(posedge clk);
            #1;
            if (rnd) bus.c_rdy = ($urandom_range(3) == 0);
            if (acc || n >= 200) break;
            n++;
        end
        stalls += n;
        bus.p_val  = 1'b0;
        bus.p_last = 1'b0;
        check("put_accept", 32'(n < 200), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int c0;
        int len;
        checks     = 0;
        errors     = 0;
        nwords     = 0;
        stalls     = 0;
        rnd        = 1'b0;
        rst_n      = 1'b0;
        bus.p      = '0;
        bus.p_last = 1'b0;
        bus.p_val  = 1'b0;
        bus.c_rdy  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_c_val", 32'(bus.c_val), 32'd0);
        check("rst_c", bus.c, 32'd0);
        check("rst_keep", 32'(bus.c_keep), 32'd0);
        check("rst_last", 32'(bus.c_last), 32'd0);
        rst_n = 1'b1;
        check("rst_p_rdy", 32'(bus.p_rdy), 32'd1);

        put(8'h11, 1'b0);
        put(8'h22, 1'b0);
        put(8'h33, 1'b0);
        put(8'h44, 1'b0);
        check("full_val", 32'(bus.c_val), 32'd1);
        check("full_c", bus.c, 32'h44332211);
        check("full_keep", 32'(bus.c_keep), 32'hF);
        check("full_last", 32'(bus.c_last), 32'd0);

        put(8'hA1, 1'b0);
        put(8'hA2, 1'b1);
        check("short_c", bus.c, 32'h0000A2A1);
        check("short_keep", 32'(bus.c_keep), 32'h3);
        check("short_last", 32'(bus.c_last), 32'd1);
        put(8'h55, 1'b1);
        check("one_c", bus.c, 32'h00000055);
        check("one_keep", 32'(bus.c_keep), 32'h1);
        check("one_last", 32'(bus.c_last), 32'd1);
        idle(2);

        bus.c_rdy = 1'b0;
        for (int i = 1; i <= 7; i++) put(8'(i), 1'b0);
        bus.p     = 8'h08;
        bus.p_val = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("bp_p_rdy", 32'(bus.p_rdy), 32'd0);
            check("bp_hold", bus.c, 32'h04030201);
        end
        @(posedge clk);
        #1;
        bus.c_rdy = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(bus.p_rdy), 32'd1);
        @(posedge clk);
        #1;
        bus.p_val = 1'b0;
        check("bp_word2_val", 32'(bus.c_val), 32'd1);
        check("bp_word2", bus.c, 32'h08070605);
        idle(1);
        check("bp_drained", 32'(bus.c_val), 32'd0);

        idle(2);
        w0     = nwords;
        c0     = cyc;
        stalls = 0;
        for (int i = 0; i < 1000; i++) put(8'(i), 1'b0);
        check("tp_cycles", 32'(cyc - c0), 32'd1000);
        idle(2);
        check("tp_words", 32'(nwords - w0), 32'd250);
        check("tp_stalls", 32'(stalls), 32'd0);

        bus.c_rdy = 1'b0;
        put(8'hC1, 1'b0);
        put(8'hC2, 1'b0);
        put(8'hC3, 1'b0);
        put(8'hC4, 1'b0);
        put(8'hC5, 1'b0);
        put(8'hC6, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mrst_val", 32'(bus.c_val), 32'd0);
        check("mrst_c", bus.c, 32'd0);
        check("mrst_keep", 32'(bus.c_keep), 32'd0);
        check("mrst_p_rdy", 32'(bus.p_rdy), 32'd1);
        bus.c_rdy = 1'b1;
        put(8'hB1, 1'b0);
        put(8'hB2, 1'b0);
        put(8'hB3, 1'b0);
        put(8'hB4, 1'b0);
        check("mrst_word", bus.c, 32'hB4B3B2B1);
        check("mrst_wkeep", 32'(bus.c_keep), 32'hF);
        idle(2);

        rnd = 1'b1;
        for (int pk = 0; pk < 40; pk++) begin
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++) put(8'($urandom), j == len - 1);
        end
        rnd       = 1'b0;
        bus.c_rdy = 1'b1;
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) idle(1);
        idle(1);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("end_c_val", 32'(bus.c_val), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stdcore_upsizer.md
STDCORE_UPSIZER -- requirements
Module: stdcore_upsizer

Interface
REQ-001 The module SHALL have parameter DW, default 8, giving the input item width in bits.
REQ-002 The module SHALL have parameter RATIO, default 4, giving the number of items packed per output word; legal values are 2..16.
REQ-003 The module SHALL have parameter CW, default 2, giving the lane counter width; it equals ceil(log2(RATIO)) and is set by the instantiator.
REQ-004 Port clk, input, 1: the single clock, rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 Port p, input, DW: input item, taken from the upstream FIFO consumer side.
REQ-007 Port p_last, input, 1: marks p as the final item of a packet and qualified by p_val.
REQ-008 Port p_val, input, 1: p and p_last are valid.
REQ-009 Port p_rdy, output, 1: the block accepts p this cycle.
REQ-010 Port c, output, DW*RATIO: packed word; lane k occupies bits [k*DW +: DW].
REQ-011 Port c_keep, output, RATIO: bit k set means lane k holds a real item.
REQ-012 Port c_last, output, 1: the word ends a packet.
REQ-013 Port c_val, output, 1: c, c_keep and c_last are valid.
REQ-014 Port c_rdy, input, 1: downstream accepts the word.

Function
REQ-015 A transfer SHALL occur on a rising clk edge when val and rdy are both 1; there is no other transfer condition.
REQ-016 The block SHALL hold an accumulator (RATIO-1 lanes plus keep bits) and a lane counter cnt (0..RATIO-1) that indexes the next free lane.
REQ-017 The block SHALL hold one output register that drives c, c_keep, c_last and c_val.
REQ-018 An accepted item SHALL be written to lane cnt.
REQ-019 An accepted item completes a word when cnt==RATIO-1 or p_last==1.
REQ-020 A non-completing accepted item SHALL be stored in the accumulator, and cnt SHALL increment.
REQ-021 On a completing accepted item, the block SHALL load the accumulator plus the item into the output register on the same edge, clear the accumulator and keep bits, and set cnt to 0.
REQ-022 For a completing item, c_last SHALL equal p_last.
REQ-023 In a completed word, unfilled lanes SHALL be zero and their c_keep bits 0; c_keep is always a contiguous run of ones starting at lane 0.
REQ-024 p_rdy SHALL equal (!c_val || c_rdy || (cnt<RATIO-1 && !p_last)).
REQ-025 p_rdy SHALL be combinational and SHALL NOT depend on p_val.
REQ-026 c_val SHALL rise on the edge that loads a completed word.
REQ-027 c_val SHALL fall on an output handshake edge unless a new completed word loads on that same edge, in which case c_val stays 1 with the new contents.
REQ-028 While c_val==1 and c_rdy==0, c, c_keep and c_last SHALL remain stable.
REQ-029 Latency from acceptance of a completing item to c_val==1 SHALL be exactly 1 cycle.
REQ-030 Sustained throughput SHALL be one item per cycle when c_rdy is held 1.
REQ-031 While the output register is occupied and not draining, non-completing items SHALL still be accepted until cnt==RATIO-1 or p_last is presented.
REQ-032 A packet of length 1 (p_last on lane 0) SHALL produce a word with c_keep=1 in lane 0 only.
REQ-033 The lane counter SHALL wrap from RATIO-1 to 0 and never exceed RATIO-1.

Reset
REQ-034 When rst_n==0 at a rising edge, the block SHALL set cnt=0, clear the accumulator and keep bits, and set c_val=0, c_last=0, c_keep=0 and c=0.
REQ-035 A reset applied mid-packet or with a word pending SHALL discard all partial and pending data, and no word from before the reset SHALL appear afterwards.
REQ-036 p_rdy SHALL be 1 in the first cycle after reset is released.

Verification
REQ-037 With DW=8, RATIO=4 and c_rdy=1, send items 0x11,0x22,0x33,0x44 back-to-back: c=0x44332211, c_keep=0xF and c_last=0 must appear one cycle after 0x44 is accepted.
REQ-038 Send 0xA1,0xA2 with p_last on 0xA2: c=0x0000A2A1, c_keep=0x3 and c_last=1, and the next packet must start in lane 0.
REQ-039 Hold c_rdy=0 and stream 8 items: the first word is held stable, the next 3 items are accepted, p_rdy==0 with the 4th pending, and after c_rdy=1 both words must drain in order.
REQ-040 Hold c_rdy=1 and run a 1000-item continuous stream: p_rdy must stay 1 throughout and one word must emit every 4 cycles.
REQ-041 Assert rst_n=0 after 2 items with a word pending: after release, c_val=0 and a new 4-item word must contain only post-reset data.
REQ-042 Random p_val/c_rdy (20-30% duty) with random packet lengths 1..9, checked against a scoreboard: all data, keep and last must match with no loss or duplication.
